// File: rtl/btn_debounce.sv
// Debounce and edge-detect for the whack-a-mole button grid.
// Everything runs on clk; the slow sample rate is a clock enable, not a divided clock.
module btn_debounce #(
   parameter int N_BTN      = 9,
   parameter int SAMPLE_DIV = 5000,
   parameter int STABLE_CNT = 10,
   localparam int IDX_W     = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             press_any,
   output logic [IDX_W-1:0] press_idx,
   output logic             sample_tick
);

   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int CNT_W = $clog2(STABLE_CNT + 1);

   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

   typedef enum logic [1:0] {
      REL        = 2'd0,
      PRESS_PEND = 2'd1,
      HELD       = 2'd2,
      REL_PEND   = 2'd3
   } stateType;

   logic [N_BTN-1:0] syncStage1;
   logic [N_BTN-1:0] syncStage2;
   logic [DIV_W-1:0] divCnt;
   stateType         btnState  [N_BTN];
   logic [CNT_W-1:0] stableCnt [N_BTN];

   // Two-flop synchronizer: the raw pins are asynchronous to clk, so only the
   // second stage is ever looked at by the debounce state machines.
   always_ff @(posedge clk) begin
      if (rst) begin
         syncStage1 <= '0;
         syncStage2 <= '0;
      end else begin
         syncStage1 <= btn_raw;
         syncStage2 <= syncStage1;
      end
   end

   // Free-running strobe counter. The strobe is decoded straight from the
   // count so it is high during the terminal count cycle, the same cycle the
   // counter wraps back to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         divCnt <= '0;
      end else if (sample_tick) begin
         divCnt <= '0;
      end else begin
         divCnt <= divCnt + DIV_W'(1);
      end
   end

   assign sample_tick = (divCnt == DIV_LAST);

   // One debounce FSM per button, all advancing only on the sample strobe.
   // A pending state counts agreeing samples; a single disagreeing sample
   // throws the count away and returns to the settled state. Level and the
   // edge pulses are registered on the edge that settles into HELD or REL,
   // so the pulse lines up with the first cycle the new level is visible.
   // Pulses default low every cycle; strobes are never back to back, so a
   // pulse can never last more than one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            btnState[i]  <= REL;
            stableCnt[i] <= '0;
         end
      end else begin
         btn_press   <= '0;
         btn_release <= '0;
         if (sample_tick) begin
            for (int i = 0; i < N_BTN; i++) begin
               case (btnState[i])
                  REL: begin
                     if (syncStage2[i]) begin
                        if (STABLE_CNT == 1) begin
                           btnState[i]  <= HELD;
                           stableCnt[i] <= '0;
                           btn_level[i] <= 1'b1;
                           btn_press[i] <= 1'b1;
                        end else begin
                           btnState[i]  <= PRESS_PEND;
                           stableCnt[i] <= CNT_W'(1);
                        end
                     end
                  end
                  PRESS_PEND: begin
                     if (!syncStage2[i]) begin
                        btnState[i]  <= REL;
                        stableCnt[i] <= '0;
                     end else if (stableCnt[i] == STABLE_LAST) begin
                        btnState[i]  <= HELD;
                        stableCnt[i] <= '0;
                        btn_level[i] <= 1'b1;
                        btn_press[i] <= 1'b1;
                     end else begin
                        stableCnt[i] <= stableCnt[i] + CNT_W'(1);
                     end
                  end
                  HELD: begin
                     if (!syncStage2[i]) begin
                        if (STABLE_CNT == 1) begin
                           btnState[i]    <= REL;
                           stableCnt[i]   <= '0;
                           btn_level[i]   <= 1'b0;
                           btn_release[i] <= 1'b1;
                        end else begin
                           btnState[i]  <= REL_PEND;
                           stableCnt[i] <= CNT_W'(1);
                        end
                     end
                  end
                  REL_PEND: begin
                     if (syncStage2[i]) begin
                        btnState[i]  <= HELD;
                        stableCnt[i] <= '0;
                     end else if (stableCnt[i] == STABLE_LAST) begin
                        btnState[i]    <= REL;
                        stableCnt[i]   <= '0;
                        btn_level[i]   <= 1'b0;
                        btn_release[i] <= 1'b1;
                     end else begin
                        stableCnt[i] <= stableCnt[i] + CNT_W'(1);
                     end
                  end
                  default: begin
                     btnState[i]  <= REL;
                     stableCnt[i] <= '0;
                  end
               endcase
            end
         end
      end
   end

   // Press encoder for the game FSM: scanning from the top down lets the
   // lowest pulsing index win when several buttons land in the same cycle.
   always_comb begin
      press_any = |btn_press;
      press_idx = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (btn_press[i]) begin
            press_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a short strobe period and stable count
// so every expected cycle offset below can be worked out by hand.
module tb_btn_debounce;

   localparam int N_BTN      = 9;
   localparam int SAMPLE_DIV = 4;
   localparam int STABLE_CNT = 3;
   localparam int IDX_W      = 4;

   logic             clk;
   logic             rst;
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic             press_any;
   logic [IDX_W-1:0] press_idx;
   logic             sample_tick;

   int assertCount;
   int failCount;
   int pressCount   [N_BTN];
   int releaseCount [N_BTN];
   int bothHighCount;
   int pressSnap    [N_BTN];
   int releaseSnap  [N_BTN];

   btn_debounce #(
      .N_BTN      (N_BTN),
      .SAMPLE_DIV (SAMPLE_DIV),
      .STABLE_CNT (STABLE_CNT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .press_any   (press_any),
      .press_idx   (press_idx),
      .sample_tick (sample_tick)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Running tally of every pulse seen, so tests can count pulses over a window.
   initial begin
      bothHighCount = 0;
      for (int i = 0; i < N_BTN; i++) begin
         pressCount[i]   = 0;
         releaseCount[i] = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < N_BTN; i++) begin
            if (btn_press[i] === 1'b1) pressCount[i]++;
            if (btn_release[i] === 1'b1) releaseCount[i]++;
            if (btn_press[i] === 1'b1 && btn_release[i] === 1'b1) bothHighCount++;
         end
      end
   end

   // Hard stop in case something blocks forever.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Wait for the next falling edge in a strobe cycle, then drive btn_raw.
   task automatic applyStimulus(input logic [N_BTN-1:0] value);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 4 * SAMPLE_DIV && !found; k++) begin
         @(negedge clk);
         if (sample_tick === 1'b1) found = 1'b1;
      end
      if (!found) checkOutput("tickTimeout", 32'd0, 32'd1);
      btn_raw = value;
   endtask

   task automatic takeSnapshot();
      #1;
      for (int i = 0; i < N_BTN; i++) begin
         pressSnap[i]   = pressCount[i];
         releaseSnap[i] = releaseCount[i];
      end
   endtask

   task automatic checkAllClear(input string tag);
      checkOutput({tag, "_level"}, 32'(btn_level), 32'h0);
      checkOutput({tag, "_press"}, 32'(btn_press), 32'h0);
      checkOutput({tag, "_release"}, 32'(btn_release), 32'h0);
      checkOutput({tag, "_anyIdxTick"}, 32'({press_any, press_idx, sample_tick}), 32'h0);
   endtask

   // Called on the falling edge that deasserts rst (cycle 0); walks to cycle 13.
   task automatic checkPostReset(input string tag, input logic [N_BTN-1:0] heldBits,
                                 input logic [IDX_W-1:0] lowIdx);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k == 1 || k == 2) checkOutput({tag, "_tickEarly"}, 32'(sample_tick), 32'd0);
         if (k == 3) checkOutput({tag, "_tickFirst"}, 32'(sample_tick), 32'd1);
         if (k == 4) checkOutput({tag, "_tickAfter"}, 32'(sample_tick), 32'd0);
         if (k == 11) begin
            checkOutput({tag, "_levelBefore"}, 32'(btn_level), 32'h0);
            checkOutput({tag, "_pressBefore"}, 32'(btn_press), 32'h0);
         end
         if (k == 12) begin
            checkOutput({tag, "_press"}, 32'(btn_press), 32'(heldBits));
            checkOutput({tag, "_level"}, 32'(btn_level), 32'(heldBits));
            checkOutput({tag, "_pressAny"}, 32'(press_any), 32'd1);
            checkOutput({tag, "_pressIdx"}, 32'(press_idx), 32'(lowIdx));
         end
         if (k == 13) begin
            checkOutput({tag, "_pressAfter"}, 32'(btn_press), 32'h0);
            checkOutput({tag, "_levelAfter"}, 32'(btn_level), 32'(heldBits));
         end
      end
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst         = 1'b1;
      btn_raw     = 9'h1FF;

      // Reset with every button held: outputs stay clear for all five cycles.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkAllClear("reset");
      end
      rst = 1'b0;
      checkPostReset("resetRelease", 9'h1FF, 4'd0);

      // Let go of everything: release pulses 13 cycles after a strobe-aligned drop.
      applyStimulus(9'h000);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k == 12) checkOutput("allRel_before", 32'(btn_release), 32'h0);
         if (k == 13) begin
            checkOutput("allRel_release", 32'(btn_release), 32'h1FF);
            checkOutput("allRel_level", 32'(btn_level), 32'h0);
         end
      end

      // Clean press of bit 4, held 40 cycles, then released.
      takeSnapshot();
      applyStimulus(9'h010);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 12) checkOutput("bit4_pressEarly", 32'(btn_press), 32'h0);
         if (k == 13) begin
            checkOutput("bit4_press", 32'(btn_press), 32'h010);
            checkOutput("bit4_pressIdx", 32'(press_idx), 32'd4);
            checkOutput("bit4_pressAny", 32'(press_any), 32'd1);
            checkOutput("bit4_level", 32'(btn_level), 32'h010);
         end
         if (k == 14) checkOutput("bit4_pressOnce", 32'(btn_press), 32'h0);
      end
      repeat (24) @(negedge clk);
      applyStimulus(9'h000);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 12) begin
            checkOutput("bit4_levelHeld", 32'(btn_level), 32'h010);
            checkOutput("bit4_releaseEarly", 32'(btn_release), 32'h0);
         end
         if (k == 13) begin
            checkOutput("bit4_release", 32'(btn_release), 32'h010);
            checkOutput("bit4_levelLow", 32'(btn_level), 32'h0);
         end
         if (k == 14) checkOutput("bit4_releaseOnce", 32'(btn_release), 32'h0);
      end
      #1;
      checkOutput("bit4_pressCount", 32'(pressCount[4] - pressSnap[4]), 32'd1);
      checkOutput("bit4_releaseCount", 32'(releaseCount[4] - releaseSnap[4]), 32'd1);

      // Bounce bit 2 every 3 cycles; strobes every 4 never see 3 equal samples.
      takeSnapshot();
      for (int seg = 0; seg < 10; seg++) begin
         @(negedge clk);
         btn_raw[2] = (seg % 2 == 0);
         repeat (2) @(negedge clk);
      end
      @(negedge clk);
      btn_raw[2] = 1'b1;
      #1;
      checkOutput("bounce_noPress", 32'(pressCount[2] - pressSnap[2]), 32'd0);
      checkOutput("bounce_noRelease", 32'(releaseCount[2] - releaseSnap[2]), 32'd0);
      repeat (20) @(negedge clk);
      #1;
      checkOutput("bounce_pressAfterHold", 32'(pressCount[2] - pressSnap[2]), 32'd1);
      checkOutput("bounce_level", 32'(btn_level), 32'h004);

      // Six-cycle glitch on bit 7 is at most two samples long and is rejected.
      takeSnapshot();
      @(negedge clk);
      btn_raw[7] = 1'b1;
      repeat (6) @(negedge clk);
      btn_raw[7] = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      checkOutput("glitch_level", 32'(btn_level[7]), 32'd0);
      checkOutput("glitch_noPress", 32'(pressCount[7] - pressSnap[7]), 32'd0);
      checkOutput("glitch_noRelease", 32'(releaseCount[7] - releaseSnap[7]), 32'd0);

      // Bits 1, 5 and 8 together while bit 2 stays held.
      applyStimulus(9'h126);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 12) checkOutput("simul_pressEarly", 32'(btn_press), 32'h0);
         if (k == 13) begin
            checkOutput("simul_press", 32'(btn_press), 32'h122);
            checkOutput("simul_pressAny", 32'(press_any), 32'd1);
            checkOutput("simul_pressIdx", 32'(press_idx), 32'd1);
            checkOutput("simul_level", 32'(btn_level), 32'h126);
         end
         if (k == 14) checkOutput("simul_pressOnce", 32'(btn_press), 32'h0);
      end

      // Bit 0 rises, two samples counted, then reset: the count must start over.
      applyStimulus(9'h127);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkAllClear("midReset1");
      @(negedge clk);
      checkAllClear("midReset2");
      rst = 1'b0;
      checkPostReset("midRelease", 9'h127, 4'd0);

      #1;
      checkOutput("pressReleaseOverlap", 32'(bothHighCount), 32'd0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
